// File: rtl/inst_aligner.sv
// Instruction aligner: packs word-aligned fetch data into whole RISC-V
// instructions (16-bit compressed or 32-bit full) using a 4-halfword FIFO.
// Handles instructions that straddle two fetch words and redirects that
// land on the upper halfword of a word. The output side is driven only
// from registered state, so there is no in_data -> out_inst path.
module inst_aligner #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic        out_is_c
);

    // FIFO storage: halfword i lives in fifo_q[16*i +: 16]; entry 0 is the oldest.
    logic [63:0] fifo_q;
    logic [63:0] fifo_d;
    logic [63:0] fifo_shifted;
    logic [2:0]  count_q;
    logic [2:0]  count_d;
    logic        drop_half_q;
    logic        drop_half_d;
    logic [31:0] pc_q;
    logic [31:0] pc_d;

    logic        head_is_c;
    logic        have_inst;
    logic        push;
    logic        pop;
    logic [1:0]  pop_n;
    logic [1:0]  push_n;
    logic [2:0]  remain;
    logic [15:0] hw_a;
    logic [15:0] hw_b;

    // Halfword alignment means flush_pc bit 0 carries no information.
    logic        unused_flush_lsb;
    assign unused_flush_lsb = flush_pc[0];

    // Head decode: RISC-V marks a full-length instruction with [1:0] == 2'b11.
    assign head_is_c = (fifo_q[1:0] != 2'b11);

    // A complete instruction is buffered if the head is compressed, or two halves exist.
    assign have_inst = ((count_q >= 3'd1) && head_is_c) || (count_q >= 3'd2);

    // Room for a whole word is judged on the current count only, never on the same-cycle pop.
    assign in_ready  = (count_q <= 3'd2) && !flush;
    assign out_valid = have_inst && !flush;
    assign out_is_c  = (count_q != 3'd0) && head_is_c;
    assign out_pc    = pc_q;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    // After a redirect onto an upper halfword, the first word's low half is not part of the stream.
    assign hw_a   = drop_half_q ? in_data[31:16] : in_data[15:0];
    assign hw_b   = in_data[31:16];
    assign push_n = push ? (drop_half_q ? 2'd1 : 2'd2) : 2'd0;
    assign pop_n  = pop  ? (head_is_c   ? 2'd1 : 2'd2) : 2'd0;
    assign remain = count_q - {1'b0, pop_n};

    // Output instruction assembled from the FIFO head; zero when nothing is buffered.
    always_comb begin
        out_inst = 32'h0000_0000;
        if (count_q != 3'd0) begin
            if (head_is_c) begin
                out_inst = {16'h0000, fifo_q[15:0]};
            end else begin
                out_inst = fifo_q[31:0];
            end
        end
    end

    // Next-state: pop first, append pushed halfwords behind what remains; flush overrides everything.
    always_comb begin
        fifo_shifted = fifo_q >> {pop_n, 4'b0000};
        fifo_d       = fifo_shifted;
        for (int i = 0; i < 4; i++) begin
            if ((push_n != 2'd0) && (remain == 3'(i))) begin
                fifo_d[16*i +: 16] = hw_a;
            end
            if ((push_n == 2'd2) && ((remain + 3'd1) == 3'(i))) begin
                fifo_d[16*i +: 16] = hw_b;
            end
        end
        count_d     = remain + {1'b0, push_n};
        drop_half_d = push ? 1'b0 : drop_half_q;
        pc_d        = pc_q;
        if (pop) begin
            pc_d = pc_q + (head_is_c ? 32'd2 : 32'd4);
        end
        if (flush) begin
            fifo_d      = 64'h0;
            count_d     = 3'd0;
            drop_half_d = flush_pc[1];
            pc_d        = {flush_pc[31:1], 1'b0};
        end
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_q      <= 64'h0;
            count_q     <= 3'd0;
            drop_half_q <= 1'b0;
            pc_q        <= RESET_PC;
        end else begin
            fifo_q      <= fifo_d;
            count_q     <= count_d;
            drop_half_q <= drop_half_d;
            pc_q        <= pc_d;
        end
    end

endmodule

// File: tb/tb_inst_aligner.sv
// Directed bench for inst_aligner with a scoreboard of expected instructions.
module tb_inst_aligner;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic [31:0] flush_pc;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        out_is_c;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        is_c;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    inst_aligner #(.RESET_PC(RESET_PC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .flush_pc  (flush_pc),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_inst  (out_inst),
        .out_pc    (out_pc),
        .out_is_c  (out_is_c)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] inst, input logic [31:0] pc, input logic is_c);
        exp_t e;
        e.inst = inst;
        e.pc   = pc;
        e.is_c = is_c;
        sb.push_back(e);
    endtask

    // One clock: sample at negedge (score any output transfer), return 1 ns after posedge.
    task automatic step(output bit acc);
        exp_t e;
        @(negedge clk);
        acc = in_valid && in_ready;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("spurious_output", 32'(out_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("out_inst", out_inst, e.inst);
                chk("out_pc", out_pc, e.pc);
                chk("out_is_c", 32'(out_is_c), 32'(e.is_c));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int k = 0; k < n; k++) step(acc);
    endtask

    task automatic send_word(input logic [31:0] data);
        bit acc;
        acc      = 1'b0;
        in_valid = 1'b1;
        in_data  = data;
        for (int k = 0; k < 20; k++) begin
            step(acc);
            if (acc) break;
        end
        chk("word_accepted", 32'(acc), 32'd1);
        in_valid = 1'b0;
        in_data  = 32'h0;
    endtask

    task automatic drain();
        bit acc;
        for (int k = 0; k < 30; k++) begin
            if (sb.size() == 0) break;
            step(acc);
        end
        chk("drain_left", 32'(sb.size()), 32'd0);
        idle(2);
        chk("idle_out_valid", 32'(out_valid), 32'd0);
    endtask

    // Redirect with a garbage word offered in the same cycle; it must be ignored.
    task automatic do_flush(input logic [31:0] pc);
        bit acc;
        flush    = 1'b1;
        flush_pc = pc;
        in_valid = 1'b1;
        in_data  = 32'hDEAD_BEEF;
        #1;
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd0);
        step(acc);
        flush    = 1'b0;
        in_valid = 1'b0;
        in_data  = 32'h0;
        chk("flush_pc_loaded", out_pc, {pc[31:1], 1'b0});
    endtask

    initial begin
        bit acc;
        rst_n     = 1'b0;
        flush     = 1'b0;
        flush_pc  = 32'h0;
        in_valid  = 1'b0;
        in_data   = 32'h0;
        out_ready = 1'b1;

        // Reset values while reset is held and right after release.
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_inst", out_inst, 32'h0);
        chk("rst_out_is_c", 32'(out_is_c), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_pc", out_pc, RESET_PC);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);
        chk("post_rst_out_valid", 32'(out_valid), 32'd0);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Two full instructions, streaming with push and pop in the same cycle.
        push_exp(32'h00A0_0513, 32'h0000_0000, 1'b0);
        push_exp(32'h00B0_0593, 32'h0000_0004, 1'b0);
        send_word(32'h00A0_0513);
        send_word(32'h00B0_0593);
        drain();

        // Two compressed instructions from one word.
        do_flush(32'h0000_0000);
        push_exp(32'h0000_4501, 32'h0000_0000, 1'b1);
        push_exp(32'h0000_4585, 32'h0000_0002, 1'b1);
        send_word(32'h4585_4501);
        drain();

        // Full instruction straddling two words stalls until the second word arrives.
        do_flush(32'h0000_0000);
        push_exp(32'h0000_4501, 32'h0000_0000, 1'b1);
        push_exp(32'h00A0_0513, 32'h0000_0002, 1'b0);
        push_exp(32'h0000_4585, 32'h0000_0006, 1'b1);
        send_word(32'h0513_4501);
        idle(2);
        chk("straddle_stall", 32'(out_valid), 32'd0);
        chk("straddle_stall_q", 32'(sb.size()), 32'd2);
        send_word(32'h4585_00A0);
        drain();

        // Redirect onto an upper halfword: low half of the first word is dropped.
        do_flush(32'h0000_0102);
        push_exp(32'h0000_4505, 32'h0000_0102, 1'b1);
        send_word(32'h4505_FFFF);
        drain();

        // PC wraps modulo 2^32.
        do_flush(32'hFFFF_FFFE);
        push_exp(32'h0000_0001, 32'hFFFF_FFFE, 1'b1);
        push_exp(32'h0000_4501, 32'h0000_0000, 1'b1);
        push_exp(32'h0000_4585, 32'h0000_0002, 1'b1);
        send_word(32'h0001_1234);
        send_word(32'h4585_4501);
        drain();

        // Backpressure: fill to 4, hold, pop one (count 3), then release.
        do_flush(32'h0000_0000);
        out_ready = 1'b0;
        push_exp(32'h0000_4501, 32'h0000_0000, 1'b1);
        push_exp(32'h0000_4585, 32'h0000_0002, 1'b1);
        push_exp(32'h0000_4605, 32'h0000_0004, 1'b1);
        push_exp(32'h0000_4685, 32'h0000_0006, 1'b1);
        send_word(32'h4585_4501);
        send_word(32'h4685_4605);
        chk("full4_in_ready", 32'(in_ready), 32'd0);
        for (int k = 0; k < 3; k++) begin
            step(acc);
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_inst", out_inst, 32'h0000_4501);
            chk("hold_pc", out_pc, 32'h0000_0000);
            chk("hold_is_c", 32'(out_is_c), 32'd1);
        end
        out_ready = 1'b1;
        step(acc);
        out_ready = 1'b0;
        chk("full3_in_ready", 32'(in_ready), 32'd0);
        chk("full3_inst", out_inst, 32'h0000_4585);
        chk("full3_pc", out_pc, 32'h0000_0002);
        out_ready = 1'b1;
        drain();

        // Asynchronous reset mid-stream at count 3 discards everything.
        do_flush(32'h0000_0000);
        out_ready = 1'b0;
        push_exp(32'h0000_4501, 32'h0000_0000, 1'b1);
        send_word(32'h4585_4501);
        send_word(32'h4685_4605);
        out_ready = 1'b1;
        step(acc);
        out_ready = 1'b0;
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", 32'(out_valid), 32'd0);
        chk("async_rst_in_ready", 32'(in_ready), 32'd1);
        chk("async_rst_out_pc", out_pc, RESET_PC);
        chk("async_rst_out_inst", out_inst, 32'h0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        idle(4);
        chk("post_rst2_out_valid", 32'(out_valid), 32'd0);
        chk("post_rst2_out_pc", out_pc, RESET_PC);
        push_exp(32'h0000_4501, RESET_PC, 1'b1);
        push_exp(32'h0000_4585, RESET_PC + 32'd2, 1'b1);
        send_word(32'h4585_4501);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_aligner.md
INST_ALIGNER -- requirements
Module: inst_aligner

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC of the first instruction after reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 flush  input  1  redirect strobe; the pending stream is discarded.
REQ-005 flush_pc  input  32  new PC, halfword aligned (bit 0 ignored), sampled when flush=1.
REQ-006 in_valid  input  1  fetch word valid.
REQ-007 in_ready  output  1  aligner accepts a fetch word this cycle.
REQ-008 in_data  input  32  word-aligned fetch data; [15:0] is the lower-address halfword.
REQ-009 out_valid  output  1  out_inst/out_pc hold one complete instruction.
REQ-010 out_ready  input  1  downstream (decompressor/decode) consumes the instruction.
REQ-011 out_inst  output  32  compressed: {16'h0000, hw}; full: {hw_hi, hw_lo}.
REQ-012 out_pc  output  32  PC of out_inst.
REQ-013 out_is_c  output  1  1 when out_inst[1:0] != 2'b11.

Function
REQ-014 The block SHALL hold a 4-entry halfword FIFO (64 bits), count 0..4; entry 0 is oldest.
REQ-015 in_ready SHALL be (count <= 2) && !flush, computed from current-cycle state, not from the same-cycle pop.
REQ-016 A word transfer (in_valid && in_ready) SHALL append in_data[15:0] then in_data[31:16]; count += 2.
REQ-017 If drop_half is set at the transfer, only in_data[31:16] SHALL be appended (count += 1) and drop_half SHALL clear.
REQ-018 out_valid SHALL be (count>=1 && entry0[1:0]!=2'b11) || count>=2, and 0 whenever flush=1.
REQ-019 out_inst, out_pc and out_is_c SHALL be driven from stored state only, with no combinational path from in_data; a word accepted in cycle N is visible at the output no earlier than N+1.
REQ-020 An output transfer (out_valid && out_ready) SHALL pop 1 halfword if out_is_c, else 2.
REQ-021 An output transfer SHALL advance out_pc by 2 (compressed) or 4 (full), wrapping modulo 2^32.
REQ-022 A push and a pop in the same cycle SHALL both take effect: count_next = count + pushed - popped.
REQ-023 A full instruction with only its low halfword buffered (count=1, entry0[1:0]=11) SHALL stall with out_valid=0 until the next word arrives.
REQ-024 flush SHALL have priority over all else: count <= 0, out_pc <= {flush_pc[31:1],1'b0}, drop_half <= flush_pc[1], any same-cycle in/out transfer ignored.
REQ-025 The fetch source SHALL restart at word {flush_pc[31:2],2'b00} after flush; this block performs no address generation.
REQ-026 When out_valid=1 and out_ready=0, out_inst/out_pc/out_is_c SHALL hold stable.
REQ-027 A full instruction straddling two fetch words SHALL be emitted with out_pc = address of its low halfword.

Reset
REQ-028 On rst_n=0, asynchronously: count=0, FIFO entries=0, drop_half=0, out_pc=RESET_PC.
REQ-029 During and immediately after reset: out_valid=0, out_inst=32'h0, out_is_c=0, in_ready=1.
REQ-030 Reset asserted mid-stream SHALL discard all buffered halfwords; no partial instruction is emitted afterwards.

Verification
REQ-031 Reset, then words 32'h00A0_0513 and 32'h00B0_0593 with out_ready=1 -> 32'h00A00513 @pc 0, then 32'h00B00593 @pc 4; out_is_c=0 both.
REQ-032 Word 32'h4585_4501 -> 32'h0000_4501 @pc 0, then 32'h0000_4585 @pc 2, out_is_c=1 both.
REQ-033 Words 32'h0513_4501, 32'h4585_00A0 -> 32'h00004501 @0, 32'h00A00513 @2 (straddle, output stalled until 2nd word), 32'h00004585 @6.
REQ-034 flush with flush_pc=32'h0000_0102, then word 32'h4505_FFFF -> 32'hFFFF half discarded; 32'h0000_4505 @pc 32'h102.
REQ-035 Assert out_ready=0 while streaming 4 compressed halfwords -> in_ready drops at count=3/4; outputs hold stable; release -> all 4 emitted in order, none lost or duplicated.
REQ-036 Pulse rst_n low while count=3 -> out_valid=0 the same cycle (async); after release out_pc=RESET_PC, count=0.
